// File: rtl/tetris_pkg.sv
// Shared types for the falling-piece controller: move opcodes, FSM states and rotation width.
// The KICK state exists only when WALL_KICK_EN is defined.
package tetris_pkg;

  localparam int ROT_W = 2;

  typedef enum logic [2:0] {
    NOP       = 3'd0,
    LEFT      = 3'd1,
    RIGHT     = 3'd2,
    DOWN      = 3'd3,
    ROT_CW    = 3'd4,
    ROT_CCW   = 3'd5,
    HARD_DROP = 3'd6
  } move_op_t;

  typedef enum logic [2:0] {
    SPAWN = 3'd0,
    IDLE  = 3'd1,
    CHECK = 3'd2,
`ifdef WALL_KICK_EN
    KICK  = 3'd3,
`endif
    DEAD  = 3'd4
  } state_t;

endpackage

// File: rtl/piece_pos_ctrl_gravity_timer.sv
// Free-running gravity divider: one tick every GRAV_DIV cycles, restartable via clr_i
// and held while freeze_i is high.
module gravity_timer #(
  parameter int unsigned GRAV_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic freeze_i,
  output logic tick_o
);

  localparam int unsigned    CNT_W = $clog2(GRAV_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(GRAV_DIV - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wrap_s;

  // Next count; clear has priority over freeze, freeze over counting
  always_comb begin
    cnt_d  = cnt_q;
    wrap_s = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (freeze_i) begin
      cnt_d = cnt_q;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      wrap_s = 1'b1;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = wrap_s;

endmodule

// File: rtl/piece_pos_ctrl.sv
// Committed piece position/rotation with collision-checked moves, gravity, lock and respawn.
// Define WALL_KICK_EN to retry a blocked rotation at x-1 and then x+1.
module piece_pos_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned XW       = 5,
  parameter int unsigned YW       = 5,
  parameter int unsigned BOARD_W  = 20,
  parameter int unsigned BOARD_H  = 24,
  parameter int unsigned SPAWN_X  = 9,
  parameter int unsigned SPAWN_Y  = 0,
  parameter int unsigned GRAV_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  move_op_t         cmd_op,
  output logic             cand_valid,
  output logic [XW-1:0]    cand_x,
  output logic [YW-1:0]    cand_y,
  output logic [ROT_W-1:0] cand_rot,
  input  logic             chk_valid,
  input  logic             chk_hit,
  output logic [XW-1:0]    pos_x,
  output logic [YW-1:0]    pos_y,
  output logic [ROT_W-1:0] rot,
  output logic             lock_pulse,
  output logic             game_over
);

  if (BOARD_W >= (2 ** XW)) begin : g_bad_board_w
    $error("BOARD_W must be smaller than 2**XW");
  end
  if (BOARD_H >= (2 ** YW)) begin : g_bad_board_h
    $error("BOARD_H must be smaller than 2**YW");
  end

  localparam logic [XW-1:0]    SPAWN_XV = XW'(SPAWN_X);
  localparam logic [YW-1:0]    SPAWN_YV = YW'(SPAWN_Y);
  localparam logic [XW-1:0]    X_ONE    = XW'(1);
  localparam logic [YW-1:0]    Y_ONE    = YW'(1);
  localparam logic [ROT_W-1:0] R_ONE    = ROT_W'(1);
  localparam logic [ROT_W-1:0] R_ZERO   = ROT_W'(0);

  state_t             state_q, state_d;
  move_op_t           op_q, op_d;
  logic               user_q, user_d;
  logic               spawn_issue_q, spawn_issue_d;
  logic               grav_pend_q, grav_pend_d;
  logic [XW-1:0]      pos_x_q, pos_x_d;
  logic [YW-1:0]      pos_y_q, pos_y_d;
  logic [ROT_W-1:0]   rot_q, rot_d;
  logic [XW-1:0]      cand_x_q, cand_x_d;
  logic [YW-1:0]      cand_y_q, cand_y_d;
  logic [ROT_W-1:0]   cand_rot_q, cand_rot_d;
  logic               cand_valid_q, cand_valid_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               lock_q, lock_d;
  logic               game_over_q, game_over_d;
`ifdef WALL_KICK_EN
  logic               kick_step_q, kick_step_d;
`endif

  logic               tick_s;
  logic               grav_clr_s;
  logic               grav_issue_s;
  logic               freeze_s;
  logic [XW-1:0]      mv_x_s;
  logic [YW-1:0]      mv_y_s;
  logic [ROT_W-1:0]   mv_rot_s;
  logic               mv_chk_s;

  assign freeze_s = (state_q == DEAD);

  gravity_timer #(
    .GRAV_DIV (GRAV_DIV)
  ) u_grav (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (grav_clr_s),
    .freeze_i (freeze_s),
    .tick_o   (tick_s)
  );

  // Candidate a user op would produce from the committed position; NOP needs no check
  always_comb begin
    mv_x_s   = pos_x_q;
    mv_y_s   = pos_y_q;
    mv_rot_s = rot_q;
    mv_chk_s = 1'b1;
    case (cmd_op)
      LEFT:            mv_x_s   = pos_x_q - X_ONE;
      RIGHT:           mv_x_s   = pos_x_q + X_ONE;
      DOWN, HARD_DROP: mv_y_s   = pos_y_q + Y_ONE;
      ROT_CW:          mv_rot_s = rot_q + R_ONE;
      ROT_CCW:         mv_rot_s = rot_q - R_ONE;
      default:         mv_chk_s = 1'b0;
    endcase
  end

  // Main FSM: next state, position commit and candidate strobes
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    user_d        = user_q;
    spawn_issue_d = spawn_issue_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    rot_d         = rot_q;
    cand_x_d      = cand_x_q;
    cand_y_d      = cand_y_q;
    cand_rot_d    = cand_rot_q;
    cand_valid_d  = 1'b0;
    lock_d        = 1'b0;
    game_over_d   = game_over_q;
    grav_clr_s    = 1'b0;
    grav_issue_s  = 1'b0;
`ifdef WALL_KICK_EN
    kick_step_d   = kick_step_q;
`endif
    case (state_q)
      SPAWN: begin
        if (spawn_issue_q) begin
          cand_x_d      = SPAWN_XV;
          cand_y_d      = SPAWN_YV;
          cand_rot_d    = R_ZERO;
          cand_valid_d  = 1'b1;
          spawn_issue_d = 1'b0;
        end else if (chk_valid) begin
          if (chk_hit) begin
            state_d     = DEAD;
            game_over_d = 1'b1;
          end else begin
            pos_x_d = cand_x_q;
            pos_y_d = cand_y_q;
            rot_d   = cand_rot_q;
            state_d = IDLE;
          end
        end else begin
          state_d = SPAWN;
        end
      end

      IDLE: begin
        // A pending gravity tick pre-empts any offered command (cmd_ready is low then)
        if (grav_pend_q) begin
          op_d         = DOWN;
          user_d       = 1'b0;
          grav_issue_s = 1'b1;
          cand_x_d     = pos_x_q;
          cand_y_d     = pos_y_q + Y_ONE;
          cand_rot_d   = rot_q;
          cand_valid_d = 1'b1;
          state_d      = CHECK;
        end else if (cmd_valid && cmd_ready_q && mv_chk_s) begin
          op_d         = cmd_op;
          user_d       = 1'b1;
          cand_x_d     = mv_x_s;
          cand_y_d     = mv_y_s;
          cand_rot_d   = mv_rot_s;
          cand_valid_d = 1'b1;
          state_d      = CHECK;
        end else begin
          state_d = IDLE;
        end
      end

      CHECK: begin
        if (chk_valid && !chk_hit) begin
          pos_x_d = cand_x_q;
          pos_y_d = cand_y_q;
          rot_d   = cand_rot_q;
          case (op_q)
            HARD_DROP: begin
              cand_y_d     = cand_y_q + Y_ONE;
              cand_valid_d = 1'b1;
              state_d      = CHECK;
            end
            DOWN: begin
              grav_clr_s = user_q;
              state_d    = IDLE;
            end
            default: state_d = IDLE;
          endcase
        end else if (chk_valid) begin
          case (op_q)
            DOWN, HARD_DROP: begin
              lock_d        = 1'b1;
              spawn_issue_d = 1'b1;
              state_d       = SPAWN;
            end
            ROT_CW, ROT_CCW: begin
`ifdef WALL_KICK_EN
              cand_x_d     = pos_x_q - X_ONE;
              cand_y_d     = pos_y_q;
              cand_valid_d = 1'b1;
              kick_step_d  = 1'b0;
              state_d      = KICK;
`else
              state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = CHECK;
        end
      end

`ifdef WALL_KICK_EN
      KICK: begin
        // cand_rot still holds the new rotation; only x is retried
        if (chk_valid && !chk_hit) begin
          pos_x_d = cand_x_q;
          pos_y_d = cand_y_q;
          rot_d   = cand_rot_q;
          state_d = IDLE;
        end else if (chk_valid && !kick_step_q) begin
          cand_x_d     = pos_x_q + X_ONE;
          cand_y_d     = pos_y_q;
          cand_valid_d = 1'b1;
          kick_step_d  = 1'b1;
          state_d      = KICK;
        end else if (chk_valid) begin
          state_d = IDLE;
        end else begin
          state_d = KICK;
        end
      end
`endif

      DEAD: begin
        game_over_d = 1'b1;
        state_d     = DEAD;
      end

      default: begin
        spawn_issue_d = 1'b1;
        state_d       = SPAWN;
      end
    endcase
  end

  // Gravity pending flag and registered command-ready
  always_comb begin
    grav_pend_d = grav_pend_q;
    if (grav_clr_s) begin
      grav_pend_d = 1'b0;
    end else if (tick_s) begin
      grav_pend_d = 1'b1;
    end else if (grav_issue_s) begin
      grav_pend_d = 1'b0;
    end else begin
      grav_pend_d = grav_pend_q;
    end
    cmd_ready_d = (state_d == IDLE) && !grav_pend_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= SPAWN;
      op_q          <= NOP;
      user_q        <= 1'b0;
      spawn_issue_q <= 1'b1;
      grav_pend_q   <= 1'b0;
      pos_x_q       <= SPAWN_XV;
      pos_y_q       <= SPAWN_YV;
      rot_q         <= R_ZERO;
      cand_x_q      <= SPAWN_XV;
      cand_y_q      <= SPAWN_YV;
      cand_rot_q    <= R_ZERO;
      cand_valid_q  <= 1'b0;
      cmd_ready_q   <= 1'b0;
      lock_q        <= 1'b0;
      game_over_q   <= 1'b0;
`ifdef WALL_KICK_EN
      kick_step_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      user_q        <= user_d;
      spawn_issue_q <= spawn_issue_d;
      grav_pend_q   <= grav_pend_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      rot_q         <= rot_d;
      cand_x_q      <= cand_x_d;
      cand_y_q      <= cand_y_d;
      cand_rot_q    <= cand_rot_d;
      cand_valid_q  <= cand_valid_d;
      cmd_ready_q   <= cmd_ready_d;
      lock_q        <= lock_d;
      game_over_q   <= game_over_d;
`ifdef WALL_KICK_EN
      kick_step_q   <= kick_step_d;
`endif
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign cand_valid = cand_valid_q;
  assign cand_x     = cand_x_q;
  assign cand_y     = cand_y_q;
  assign cand_rot   = cand_rot_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign rot        = rot_q;
  assign lock_pulse = lock_q;
  assign game_over  = game_over_q;

endmodule
